// File: rtl/bw_clk_cl_ctl_if.sv
// Signal bundle for the cluster clock-enable sequencer: async requests in,
// registered cluster enables/reset and status out, plus the FSM state for debug.
interface bw_clk_cl_ctl_if #(
  parameter int NCL = 4
);
  // Requests are level signals with no handshake: the sequencer samples them
  // through 2-flop synchronizers, and every output is a registered level.
  logic           en_req;
  logic           dbg_stop;
  logic           dbg_step;
  logic [NCL-1:0] cl_en;
  logic           cl_rst_l;
  logic           clk_stable;
  logic           busy;
  logic [2:0]     state;

  modport master (
    output en_req, dbg_stop, dbg_step,
    input  cl_en, cl_rst_l, clk_stable, busy, state
  );

  modport slave (
    input  en_req, dbg_stop, dbg_step,
    output cl_en, cl_rst_l, clk_stable, busy, state
  );
endinterface

// File: rtl/bw_clk_cl_ctl.sv
// Cluster clock-enable sequencer: staggers per-cluster enables on ramp up/down,
// releases cluster reset after the ramp, and supports debug freeze/single-step.
module bw_clk_cl_ctl #(
  parameter int NCL      = 4,
  parameter int GAP      = 4,
  parameter int RST_HOLD = 16,
  parameter int STEP_LEN = 2
) (
  input  logic             rclk,
  input  logic             arst,
  bw_clk_cl_ctl_if.slave   bus
);

  localparam int MAXC = (GAP > RST_HOLD) ? ((GAP > STEP_LEN) ? GAP : STEP_LEN)
                                         : ((RST_HOLD > STEP_LEN) ? RST_HOLD : STEP_LEN);
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [NCL-1:0] ONES = '1;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_RAMP_UP = 3'd1,
    S_HOLD    = 3'd2,
    S_RUN     = 3'd3,
    S_RAMP_DN = 3'd4,
    S_FROZEN  = 3'd5
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [NCL-1:0] cl_en;
  logic           cl_rst_l;
  logic           clk_stable;
  logic           busy;

  logic en_m, en_s, stop_m, stop_s, step_m, step_s, step_q;
  logic step_rise;

  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      en_m   <= 1'b0;
      en_s   <= 1'b0;
      stop_m <= 1'b0;
      stop_s <= 1'b0;
      step_m <= 1'b0;
      step_s <= 1'b0;
      step_q <= 1'b0;
    end else begin
      en_m   <= bus.en_req;
      en_s   <= en_m;
      stop_m <= bus.dbg_stop;
      stop_s <= stop_m;
      step_m <= bus.dbg_step;
      step_s <= step_m;
      step_q <= step_s;
    end
  end

  assign step_rise = step_s & ~step_q;

  // Enables are always a contiguous run from bit 0, so ramps are plain shifts.
  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      state      <= S_OFF;
      cnt        <= '0;
      cl_en      <= '0;
      cl_rst_l   <= 1'b0;
      clk_stable <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_OFF: begin
          if (en_s) begin
            state <= S_RAMP_UP;
            cl_en <= NCL'(1);
            cnt   <= CW'(GAP - 1);
            busy  <= 1'b1;
          end
        end
        S_RAMP_UP: begin
          if (!en_s) begin
            state <= S_RAMP_DN;
            cnt   <= CW'(GAP - 1);
          end else if (cnt == '0) begin
            cl_en <= {cl_en[NCL-2:0], 1'b1};
            if (cl_en[NCL-2]) begin
              state <= S_HOLD;
              cnt   <= CW'(RST_HOLD - 1);
            end else begin
              cnt <= CW'(GAP - 1);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (!en_s) begin
            state <= S_RAMP_DN;
            cnt   <= CW'(GAP - 1);
          end else if (cnt == '0) begin
            state      <= S_RUN;
            cl_rst_l   <= 1'b1;
            clk_stable <= 1'b1;
            busy       <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RUN: begin
          if (!en_s) begin
            state      <= S_RAMP_DN;
            cnt        <= CW'(GAP - 1);
            cl_rst_l   <= 1'b0;
            clk_stable <= 1'b0;
            busy       <= 1'b1;
          end else if (stop_s) begin
            state      <= S_FROZEN;
            cl_en      <= '0;
            clk_stable <= 1'b0;
          end
        end
        S_RAMP_DN: begin
          // en_s is deliberately ignored here; OFF restarts the ramp cleanly.
          if (cnt == '0) begin
            cl_en <= cl_en >> 1;
            if (cl_en[NCL-1:1] == '0) begin
              state <= S_OFF;
              busy  <= 1'b0;
            end else begin
              cnt <= CW'(GAP - 1);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_FROZEN: begin
          if (!en_s) begin
            state    <= S_OFF;
            cl_en    <= '0;
            cl_rst_l <= 1'b0;
          end else if (!stop_s) begin
            state      <= S_RUN;
            cl_en      <= ONES;
            clk_stable <= 1'b1;
          end else if (cl_en[0]) begin
            // Step in progress; new step requests are dropped until it ends.
            if (cnt == '0) cl_en <= '0;
            else           cnt   <= cnt - 1'b1;
          end else if (step_rise) begin
            cl_en <= ONES;
            cnt   <= CW'(STEP_LEN - 1);
          end
        end
        default: begin
          state      <= S_OFF;
          cl_en      <= '0;
          cl_rst_l   <= 1'b0;
          clk_stable <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cl_en      = cl_en;
  assign bus.cl_rst_l   = cl_rst_l;
  assign bus.clk_stable = clk_stable;
  assign bus.busy       = busy;
  assign bus.state      = state;

endmodule

// File: tb/tb_bw_clk_cl_ctl.sv
// Bench for bw_clk_cl_ctl: scenarios push timed output-change events computed
// from the ramp/step timing rules; a negedge monitor pops and compares them.
module tb_bw_clk_cl_ctl;
  localparam int NCL      = 4;
  localparam int GAP      = 4;
  localparam int RST_HOLD = 16;
  localparam int STEP_LEN = 2;
  localparam int W        = 32 + NCL + 3;
  localparam logic [NCL-1:0] ONES = '1;

  logic rclk = 1'b0;
  logic arst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  logic [W-1:0]     exp_q[$];
  logic [NCL+2:0]   prev_out;

  bw_clk_cl_ctl_if #(.NCL(NCL)) bus ();

  bw_clk_cl_ctl #(
    .NCL(NCL), .GAP(GAP), .RST_HOLD(RST_HOLD), .STEP_LEN(STEP_LEN)
  ) dut (
    .rclk (rclk),
    .arst (arst),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 rclk = ~rclk;
  always @(posedge rclk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic logic [NCL-1:0] fill(input int n);
    return NCL'((1 << n) - 1);
  endfunction

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) tick();
  endtask

  // Inputs driven here are sampled at edge s.
  task automatic drive_at(input int s);
    wait_until(s - 1);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic push_ev(input int e, input logic [NCL-1:0] en,
                         input logic r, input logic s, input logic b);
    exp_q.push_back({32'(e), en, r, s, b});
  endtask

  // Enables rise at k+2, then every GAP; reset release RST_HOLD after the last one.
  task automatic push_ramp_up(input int k, input bit with_run, output int run_e);
    for (int i = 0; i < NCL; i++) push_ev(k + 2 + i * GAP, fill(i + 1), 1'b0, 1'b0, 1'b1);
    run_e = k + 2 + (NCL - 1) * GAP + RST_HOLD;
    if (with_run) push_ev(run_e, ONES, 1'b1, 1'b1, 1'b0);
  endtask

  // c enabled clusters drop one per GAP starting GAP after ramp-down entry e.
  task automatic push_ramp_dn(input int e, input int c);
    for (int j = 1; j <= c; j++) push_ev(e + j * GAP, fill(c - j), 1'b0, 1'b0, j < c);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge rclk) begin
    logic [NCL+2:0] cur;
    logic [W-1:0]   ev;
    if (mon_en) begin
      while (exp_q.size() > 0 && int'(exp_q[0][W-1:NCL+3]) < cyc) begin
        ev = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event expected edge %0d val %b, nothing changed (now edge %0d)",
                 ev[W-1:NCL+3], ev[NCL+2:0], cyc);
      end
      cur = {bus.cl_en, bus.cl_rst_l, bus.clk_stable, bus.busy};
      if (cur !== prev_out) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change edge %0d got %b", cyc, cur);
        end else begin
          ev = exp_q.pop_front();
          if (ev !== {32'(cyc), cur}) begin
            errors++;
            $display("FAIL out_event got edge %0d val %b expected edge %0d val %b",
                     cyc, cur, ev[W-1:NCL+3], ev[NCL+2:0]);
          end
        end
        prev_out = cur;
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic ramp_up_to_run();
    int k, run_e;
    k = cyc + 1 + int'($urandom_range(0, 3));
    push_ramp_up(k, 1'b1, run_e);
    drive_at(k);
    bus.en_req = 1'b1;
    wait_until(run_e + int'($urandom_range(2, 6)));
  endtask

  task automatic ramp_down_run();
    int k;
    bit with_stop;
    k = cyc + 1 + int'($urandom_range(0, 3));
    with_stop = 1'($urandom_range(0, 1));
    push_ev(k + 2, ONES, 1'b0, 1'b0, 1'b1);
    push_ramp_dn(k + 2, NCL);
    drive_at(k);
    bus.en_req = 1'b0;
    if (with_stop) bus.dbg_stop = 1'b1;
    wait_until(k + 2 + NCL * GAP + 2);
    bus.dbg_stop = 1'b0;
  endtask

  task automatic do_debug(input bit end_unstop, output bit in_run);
    int ks, kp, ke, nst, last_s;
    bit dbl, last;
    ks = cyc + 1 + int'($urandom_range(0, 2));
    push_ev(ks + 2, '0, 1'b1, 1'b0, 1'b0);
    drive_at(ks);
    bus.dbg_stop = 1'b1;
    nst = int'($urandom_range(1, 3));
    kp = ks + int'($urandom_range(1, 4));
    ke = 0;
    for (int st = 0; st < nst; st++) begin
      dbl  = 1'($urandom_range(0, 1));
      last = (st == nst - 1);
      push_ev(kp + 2, ONES, 1'b1, 1'b0, 1'b0);
      if (last) begin
        ke = kp + int'($urandom_range(1, 6));
        if (kp + 2 + STEP_LEN < ke + 2) push_ev(kp + 2 + STEP_LEN, '0, 1'b1, 1'b0, 1'b0);
        if (end_unstop) push_ev(ke + 2, ONES, 1'b1, 1'b1, 1'b0);
        else            push_ev(ke + 2, '0, 1'b0, 1'b0, 1'b0);
      end else begin
        push_ev(kp + 2 + STEP_LEN, '0, 1'b1, 1'b0, 1'b0);
      end
      last_s = (last && ke > kp + 3) ? ke : kp + 3;
      for (int s = kp; s <= last_s; s++) begin
        drive_at(s);
        bus.dbg_step = (s == kp) || (dbl && s == kp + 2);
        if (last && s == ke) begin
          if (end_unstop) bus.dbg_stop = 1'b0;
          else            bus.en_req   = 1'b0;
        end
      end
      if (!last) kp = kp + STEP_LEN + int'($urandom_range(4, 7));
    end
    wait_until(ke + 4);
    bus.dbg_stop = 1'b0;
    in_run = end_unstop;
  endtask

  task automatic do_abort(input bit re, output bit in_run);
    int k0, k1, k2, e, c, off_e, run_e;
    k0 = cyc + 1 + int'($urandom_range(0, 2));
    k1 = k0 + int'($urandom_range(1, (NCL - 1) * GAP + RST_HOLD));
    e  = k1 + 2;
    c  = 0;
    for (int i = 0; i < NCL; i++) if (k0 + 2 + i * GAP < e) c++;
    for (int i = 0; i < c; i++) push_ev(k0 + 2 + i * GAP, fill(i + 1), 1'b0, 1'b0, 1'b1);
    push_ramp_dn(e, c);
    off_e = e + c * GAP;
    k2 = 0;
    run_e = 0;
    if (re) begin
      k2 = int'($urandom_range(k1 + 1, off_e - 1));
      push_ramp_up(off_e - 1, 1'b1, run_e);
    end
    drive_at(k0);
    bus.en_req = 1'b1;
    drive_at(k1);
    bus.en_req = 1'b0;
    if (re) begin
      drive_at(k2);
      bus.en_req = 1'b1;
      wait_until(run_e + 3);
    end else begin
      wait_until(off_e + 3);
    end
    in_run = re;
  endtask

  task automatic do_reset_mid_hold();
    int k, run_e;
    k = cyc + 1 + int'($urandom_range(0, 2));
    push_ramp_up(k, 1'b0, run_e);
    drive_at(k);
    bus.en_req = 1'b1;
    wait_until(run_e - int'($urandom_range(1, RST_HOLD - 1)));
    #2;
    push_ev(cyc, '0, 1'b0, 1'b0, 1'b0);
    arst = 1'b1;
    #1;
    check("arst_cl_en",      32'(bus.cl_en),      32'd0);
    check("arst_cl_rst_l",   32'(bus.cl_rst_l),   32'd0);
    check("arst_clk_stable", 32'(bus.clk_stable), 32'd0);
    check("arst_busy",       32'(bus.busy),       32'd0);
    repeat (3) tick();
    arst = 1'b0;
    k = cyc + 1;
    push_ramp_up(k, 1'b1, run_e);
    wait_until(run_e + 3);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit in_run;
    arst         = 1'b1;
    bus.en_req   = 1'b0;
    bus.dbg_stop = 1'b0;
    bus.dbg_step = 1'b0;
    prev_out     = '0;
    repeat (5) tick();
    check("reset_cl_en",      32'(bus.cl_en),      32'd0);
    check("reset_cl_rst_l",   32'(bus.cl_rst_l),   32'd0);
    check("reset_clk_stable", 32'(bus.clk_stable), 32'd0);
    check("reset_busy",       32'(bus.busy),       32'd0);
    check("reset_state",      32'(bus.state),      32'd0);
    arst   = 1'b0;
    mon_en = 1;

    for (int r = 0; r < 4; r++) begin
      ramp_up_to_run();
      in_run = 1;
      if (r < 2) do_debug(r == 0, in_run);
      else if ($urandom_range(0, 1) == 1) do_debug(1'($urandom_range(0, 1)), in_run);
      if (in_run) ramp_down_run();
      repeat (int'($urandom_range(1, 4))) tick();
      do_abort((r == 0) ? 1'b1 : (r == 1) ? 1'b0 : 1'($urandom_range(0, 1)), in_run);
      if (in_run) ramp_down_run();
      repeat (int'($urandom_range(1, 4))) tick();
    end

    do_reset_mid_hold();
    ramp_down_run();

    repeat (10) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop in case a scenario ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout at edge %0d", cyc);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
